// File: rtl/output_buffer_ctrl_if.sv
// Result handshake bundle between output_buffer_ctrl (master) and the core (slave).
// Carries the 32-bit lane-code word, its valid/ready pair and the completion pulse.
interface output_buffer_ctrl_if;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        result_ready_i;
  logic        done_o;

  modport master (
    output result_o,
    output result_valid_o,
    output done_o,
    input  result_ready_i
  );

  modport slave (
    input  result_o,
    input  result_valid_o,
    input  done_o,
    output result_ready_i
  );
endinterface

// File: rtl/output_buffer_ctrl.sv
// Sequences one PIM readout: ADC capture into output buffers, encoder wait, result handshake.
// Optional statistics counters are enabled by defining OUTBUF_CTRL_STATS_EN.
module output_buffer_ctrl #(
  parameter int ENC_LAT     = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [2:0]          mode_i,
  input  logic                adc_valid_i,
  input  logic [3:0][6:0]     encoder_output_i,
  output logic [2:0]          pim_mode_o,
  output logic                buf_load_1_o,
  output logic                buf_load_2_o,
  output logic                busy_o,
  output logic                err_o,
`ifdef OUTBUF_CTRL_STATS_EN
  output logic [15:0]         done_cnt_o,
  output logic [7:0]          err_cnt_o,
  input  logic                stats_clr_i,
`endif
  output_buffer_ctrl_if.master res_if
);

  typedef enum logic [2:0] {
    IDLE,
    CAP1,
    CAP2,
    ENC_WAIT,
    OUT
  } state_e;

  typedef enum logic [2:0] {
    MODE_NONE     = 3'b000,
    MODE_PARALLEL = 3'b101,
    MODE_RBR      = 3'b110
  } mode_e;

  // One wait counter serves both the ADC timeout and the encoder latency.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [7:0] LAT_LAST = 8'(ENC_LAT - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  mode_e       r_mode;
  logic [7:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_done;
  logic        r_err;

  logic        w_load1;
  logic        w_load2;
  logic        w_mode_ld;
  logic        w_capture;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_mode_legal;

  assign w_mode_legal = (mode_i == MODE_PARALLEL) || (mode_i == MODE_RBR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load1     = 1'b0;
    w_load2     = 1'b0;
    w_mode_ld   = 1'b0;
    w_capture   = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          if (w_mode_legal) begin
            w_mode_ld   = 1'b1;
            w_state_nxt = CAP1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      CAP1: begin
        if (adc_valid_i) begin
          w_load1     = 1'b1;
          w_state_nxt = (r_mode == MODE_PARALLEL) ? CAP2 : ENC_WAIT;
        end else if (r_cnt == TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      CAP2: begin
        if (adc_valid_i) begin
          w_load2     = 1'b1;
          w_state_nxt = ENC_WAIT;
        end else if (r_cnt == TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      ENC_WAIT: begin
        if (r_cnt == LAT_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        if (res_if.result_ready_i) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter restarts on every state entry and only runs in the timed states.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if ((w_state_nxt != r_state) || (r_state == IDLE) || (r_state == OUT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mode   <= MODE_NONE;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (w_mode_ld) r_mode <= mode_e'(mode_i);
      if (w_capture) begin
        for (int i = 0; i < 4; i++) begin
          r_result[8*i +: 8] <= {1'b0, encoder_output_i[i]};
        end
      end
    end
  end

  assign busy_o                = (r_state != IDLE);
  assign pim_mode_o            = busy_o ? r_mode : MODE_NONE;
  assign buf_load_1_o          = w_load1;
  assign buf_load_2_o          = w_load2;
  assign err_o                 = r_err;
  assign res_if.result_o       = r_result;
  assign res_if.result_valid_o = (r_state == OUT);
  assign res_if.done_o         = r_done;

`ifdef OUTBUF_CTRL_STATS_EN
  logic [15:0] r_done_cnt;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || stats_clr_i) begin
      r_done_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_done_nxt)                          r_done_cnt <= r_done_cnt + 16'd1;
      if (w_err_nxt && (r_err_cnt != 8'hFF))   r_err_cnt  <= r_err_cnt + 8'd1;
    end
  end

  assign done_cnt_o = r_done_cnt;
  assign err_cnt_o  = r_err_cnt;
`endif

endmodule
